datapath_pipe: RTL and testbench

Parametrised two-stage successor to the single-cycle datapath. It couples a resettable register file, a synchronous-read data memory, an ALU and a write-back mux, and adds a registered execute stage with full result forwarding, so a new operation can issue every cycle. It sits under the control FSM, which drives one operation word per cycle and reads ALU operands/results back for debug and branching.

---
 rtl/datapath_pipe_if.sv | 40 ++++
 rtl/datapath_pipe.sv | 104 ++++++++++
 tb/tb_datapath_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_pipe_if.sv
// Operation-issue and execute/write-back bundle between the control FSM and datapath_pipe.
// The FSM side takes the master modport; the datapath takes the slave modport.
interface datapath_pipe_if #(
    parameter int DW  = 16,
    parameter int RAW = 4,
    parameter int DAW = 8
);
    logic           op_valid;
    logic [2:0]     op_alu_s;
    logic [RAW-1:0] op_ra_addr;
    logic [RAW-1:0] op_rb_addr;
    logic [RAW-1:0] op_w_addr;
    logic           op_w_en;
    logic           op_mux_s;
    logic [DAW-1:0] op_d_addr;
    logic           op_d_we;

    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [DW-1:0]  alu_out;
    logic           alu_zero;
    logic           alu_carry;
    logic           wb_valid;
    logic [RAW-1:0] wb_addr;
    logic [DW-1:0]  wb_data;

    modport master (
        output op_valid, op_alu_s, op_ra_addr, op_rb_addr, op_w_addr,
               op_w_en, op_mux_s, op_d_addr, op_d_we,
        input  alu_a, alu_b, alu_out, alu_zero, alu_carry,
               wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  op_valid, op_alu_s, op_ra_addr, op_rb_addr, op_w_addr,
               op_w_en, op_mux_s, op_d_addr, op_d_we,
        output alu_a, alu_b, alu_out, alu_zero, alu_carry,
               wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage datapath: register read/forward and memory access in ID, ALU and write-back in EX.
// Full EX-to-ID forwarding lets dependent operations issue back to back without bubbles.
module datapath_pipe #(
    parameter int DW  = 16,
    parameter int RAW = 4,
    parameter int DAW = 8
) (
    input logic         clk,
    input logic         reset_n,
    datapath_pipe_if.slave bus
);
    localparam int NREG = 2 ** RAW;
    localparam int NMEM = 2 ** DAW;

    logic [DW-1:0]  regs [NREG];
    logic [DW-1:0]  mem  [NMEM];
    logic [DW-1:0]  mem_q;

    logic [DW-1:0]  ex_a;
    logic [DW-1:0]  ex_b;
    logic [2:0]     ex_alu_s;
    logic [RAW-1:0] ex_w_addr;
    logic           ex_mux_s;
    logic           ex_valid;

    logic [DW-1:0]  fwd_a;
    logic [DW-1:0]  fwd_b;
    logic [DW:0]    alu_wide;
    logic [DW-1:0]  wb_data;

    // The committing EX write shadows the register file, covering the same-cycle write/read case.
    always_comb begin
        fwd_a = regs[bus.op_ra_addr];
        fwd_b = regs[bus.op_rb_addr];
        if (ex_valid && (ex_w_addr == bus.op_ra_addr)) begin
            fwd_a = wb_data;
        end
        if (ex_valid && (ex_w_addr == bus.op_rb_addr)) begin
            fwd_b = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (ex_valid) begin
            regs[ex_w_addr] <= wb_data;
        end
    end

    // Memory is not reset; the read samples the old word when a store hits the same address.
    always_ff @(posedge clk) begin
        if (bus.op_valid && bus.op_d_we) begin
            mem[bus.op_d_addr] <= fwd_a;
        end
        mem_q <= mem[bus.op_d_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_a      <= '0;
            ex_b      <= '0;
            ex_alu_s  <= '0;
            ex_w_addr <= '0;
            ex_mux_s  <= 1'b0;
            ex_valid  <= 1'b0;
        end else begin
            ex_a      <= fwd_a;
            ex_b      <= fwd_b;
            ex_alu_s  <= bus.op_alu_s;
            ex_w_addr <= bus.op_w_addr;
            ex_mux_s  <= bus.op_mux_s;
            ex_valid  <= bus.op_valid & bus.op_w_en;
        end
    end

    // Bit DW carries the add carry or subtract borrow; logic ops leave it clear.
    always_comb begin
        alu_wide = '0;
        case (ex_alu_s)
            3'd1:    alu_wide = {1'b0, ex_a} + {1'b0, ex_b};
            3'd2:    alu_wide = {1'b0, ex_a} - {1'b0, ex_b};
            3'd3:    alu_wide = {1'b0, ex_a};
            3'd4:    alu_wide = {1'b0, ex_a ^ ex_b};
            3'd5:    alu_wide = {1'b0, ex_a | ex_b};
            3'd6:    alu_wide = {1'b0, ex_a & ex_b};
            3'd7:    alu_wide = {1'b0, ex_a} + {{DW{1'b0}}, 1'b1};
            default: alu_wide = '0;
        endcase
    end

    assign wb_data       = ex_mux_s ? mem_q : alu_wide[DW-1:0];

    assign bus.alu_a     = ex_a;
    assign bus.alu_b     = ex_b;
    assign bus.alu_out   = alu_wide[DW-1:0];
    assign bus.alu_zero  = (alu_wide[DW-1:0] == '0);
    assign bus.alu_carry = alu_wide[DW];
    assign bus.wb_valid  = ex_valid;
    assign bus.wb_addr   = ex_w_addr;
    assign bus.wb_data   = wb_data;
endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed and random operations checked against a sequential
// register/memory model, plus a narrow DW=8 instance for the parameter variant.
module tb_datapath_pipe;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    datapath_pipe_if #(.DW(16), .RAW(4), .DAW(8)) bus ();
    datapath_pipe #(.DW(16), .RAW(4), .DAW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    datapath_pipe_if #(.DW(8), .RAW(3), .DAW(4)) vbus ();
    datapath_pipe #(.DW(8), .RAW(3), .DAW(4)) vdut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (vbus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Architectural view: every op sees the effect of all ops issued before it.
    logic [15:0] m_regs  [16];
    logic [15:0] m_mem   [256];
    bit          m_known [256];

    bit          r_valid, r_wen, r_mux, r_dwe;
    logic [2:0]  r_alu;
    logic [3:0]  r_ra, r_rb, r_w;
    logic [7:0]  r_da;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void alu_model(input int code, input int a, input int b,
                                      output int res, output int cy);
        res = 0;
        cy  = 0;
        case (code)
            1: begin res = (a + b) % 65536; cy = (a + b >= 65536) ? 1 : 0; end
            2: begin res = (a - b + 65536) % 65536; cy = (a < b) ? 1 : 0; end
            3: res = a;
            4: res = a ^ b;
            5: res = a | b;
            6: res = a & b;
            7: begin res = (a + 1) % 65536; cy = (a + 1 >= 65536) ? 1 : 0; end
            default: res = 0;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.op_valid   = 1'b0; bus.op_alu_s   = '0; bus.op_ra_addr = '0;
        bus.op_rb_addr = '0;   bus.op_w_addr  = '0; bus.op_w_en    = 1'b0;
        bus.op_mux_s   = 1'b0; bus.op_d_addr  = '0; bus.op_d_we    = 1'b0;
        vbus.op_valid   = 1'b0; vbus.op_alu_s   = '0; vbus.op_ra_addr = '0;
        vbus.op_rb_addr = '0;   vbus.op_w_addr  = '0; vbus.op_w_en    = 1'b0;
        vbus.op_mux_s   = 1'b0; vbus.op_d_addr  = '0; vbus.op_d_we    = 1'b0;
    endtask

    task automatic check_output(input logic [15:0] ea, input logic [15:0] eb,
                                input int er, input int ec, input bit ev,
                                input logic [3:0] ew, input logic [15:0] ewd);
        check("alu_a",     bus.alu_a,     ea);
        check("alu_b",     bus.alu_b,     eb);
        check("alu_out",   bus.alu_out,   er[15:0]);
        check("alu_zero",  bus.alu_zero,  (er == 0) ? 1 : 0);
        check("alu_carry", bus.alu_carry, ec[0]);
        check("wb_valid",  bus.wb_valid,  ev);
        check("wb_addr",   bus.wb_addr,   ew);
        if (ev) check("wb_data", bus.wb_data, ewd);
    endtask

    // Called at a falling edge; returns at the next falling edge with the op in EX.
    task automatic apply_stimulus(input bit v, input logic [2:0] alu_s,
                                  input logic [3:0] ra, input logic [3:0] rb,
                                  input logic [3:0] w, input bit wen, input bit mux,
                                  input logic [7:0] da, input bit dwe);
        logic [15:0] ea, eb, wbd;
        int er, ec;
        bus.op_valid   = v;   bus.op_alu_s  = alu_s; bus.op_ra_addr = ra;
        bus.op_rb_addr = rb;  bus.op_w_addr = w;     bus.op_w_en    = wen;
        bus.op_mux_s   = mux; bus.op_d_addr = da;    bus.op_d_we    = dwe;
        ea = m_regs[ra];
        eb = m_regs[rb];
        alu_model(int'(alu_s), int'(ea), int'(eb), er, ec);
        wbd = mux ? m_mem[da] : er[15:0];
        if (v && dwe) begin
            m_mem[da]   = ea;
            m_known[da] = 1'b1;
        end
        if (v && wen) m_regs[w] = wbd;
        @(negedge clk);
        check_output(ea, eb, er, ec, v && wen, w, wbd);
    endtask

    // Builds a constant in register r by clearing, then doubling and incrementing.
    task automatic set_const(input logic [3:0] r, input logic [15:0] val);
        apply_stimulus(1, 3'd0, 4'd0, 4'd0, r, 1, 0, 8'd0, 0);
        for (int i = 15; i >= 0; i--) begin
            apply_stimulus(1, 3'd1, r, r, r, 1, 0, 8'd0, 0);
            if (val[i]) apply_stimulus(1, 3'd7, r, r, r, 1, 0, 8'd0, 0);
        end
    endtask

    task automatic v_op(input logic [2:0] alu_s, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] w, input bit wen, input bit mux,
                        input logic [3:0] da, input bit dwe);
        vbus.op_valid   = 1'b1; vbus.op_alu_s  = alu_s; vbus.op_ra_addr = ra;
        vbus.op_rb_addr = rb;   vbus.op_w_addr = w;     vbus.op_w_en    = wen;
        vbus.op_mux_s   = mux;  vbus.op_d_addr = da;    vbus.op_d_we    = dwe;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_alu_a",     bus.alu_a,     16'h0);
        check("rst_alu_b",     bus.alu_b,     16'h0);
        check("rst_alu_out",   bus.alu_out,   16'h0);
        check("rst_alu_zero",  bus.alu_zero,  1'b1);
        check("rst_alu_carry", bus.alu_carry, 1'b0);
        check("rst_wb_valid",  bus.wb_valid,  1'b0);
        check("rst_wb_addr",   bus.wb_addr,   4'h0);
        check("rst_wb_data",   bus.wb_data,   16'h0);
        check("v_rst_zero",    vbus.alu_zero, 1'b1);
        reset_n = 1'b1;

        $display("[TB] back-to-back load dependency");
        set_const(4'd3, 16'h0007);
        apply_stimulus(1, 3'd0, 4'd3, 4'd0, 4'd0, 0, 0, 8'h05, 1);
        apply_stimulus(1, 3'd0, 4'd0, 4'd0, 4'd1, 1, 1, 8'h05, 0);
        check("dep_load", bus.wb_data, 16'h0007);
        apply_stimulus(1, 3'd1, 4'd1, 4'd1, 4'd2, 1, 0, 8'h00, 0);
        check("dep_add", bus.wb_data, 16'h000E);

        $display("[TB] ALU sweep A=0xFFFF B=0x0001");
        set_const(4'd4, 16'hFFFF);
        set_const(4'd5, 16'h0001);
        apply_stimulus(1, 3'd1, 4'd4, 4'd5, 4'd0, 0, 0, 8'h00, 0);
        check("add_out", bus.alu_out, 16'h0000);
        check("add_zero", bus.alu_zero, 1'b1);
        check("add_carry", bus.alu_carry, 1'b1);
        apply_stimulus(1, 3'd2, 4'd4, 4'd5, 4'd0, 0, 0, 8'h00, 0);
        check("sub_out", bus.alu_out, 16'hFFFE);
        check("sub_carry", bus.alu_carry, 1'b0);
        apply_stimulus(1, 3'd7, 4'd4, 4'd5, 4'd0, 0, 0, 8'h00, 0);
        check("inc_out", bus.alu_out, 16'h0000);
        check("inc_carry", bus.alu_carry, 1'b1);
        apply_stimulus(1, 3'd4, 4'd4, 4'd5, 4'd0, 0, 0, 8'h00, 0);
        check("xor_out", bus.alu_out, 16'hFFFE);
        apply_stimulus(1, 3'd5, 4'd4, 4'd5, 4'd0, 0, 0, 8'h00, 0);
        check("or_out", bus.alu_out, 16'hFFFF);
        apply_stimulus(1, 3'd6, 4'd4, 4'd5, 4'd0, 0, 0, 8'h00, 0);
        check("and_out", bus.alu_out, 16'h0001);

        $display("[TB] store then load, combined store+load");
        set_const(4'd3, 16'h1234);
        set_const(4'd7, 16'h00AB);
        apply_stimulus(1, 3'd0, 4'd3, 4'd0, 4'd0, 0, 0, 8'h10, 1);
        apply_stimulus(1, 3'd0, 4'd0, 4'd0, 4'd6, 1, 1, 8'h10, 0);
        check("st_ld", bus.wb_data, 16'h1234);
        apply_stimulus(1, 3'd0, 4'd7, 4'd0, 4'd8, 1, 1, 8'h10, 1);
        check("st_ld_same_op", bus.wb_data, 16'h1234);
        apply_stimulus(1, 3'd0, 4'd0, 4'd0, 4'd9, 1, 1, 8'h10, 0);
        check("ld_after_st", bus.wb_data, 16'h00AB);

        $display("[TB] bubble");
        apply_stimulus(1, 3'd0, 4'd3, 4'd0, 4'd0, 0, 0, 8'h30, 1);
        apply_stimulus(1, 3'd3, 4'd4, 4'd0, 4'd10, 1, 0, 8'h00, 0);
        check("bub_pre", bus.wb_valid, 1'b1);
        apply_stimulus(0, 3'd7, 4'd4, 4'd0, 4'd11, 1, 0, 8'h30, 1);
        check("bub_gap", bus.wb_valid, 1'b0);
        apply_stimulus(1, 3'd3, 4'd11, 4'd0, 4'd12, 1, 0, 8'h00, 0);
        check("bub_post", bus.wb_valid, 1'b1);
        apply_stimulus(1, 3'd0, 4'd0, 4'd0, 4'd13, 1, 1, 8'h30, 0);
        check("bub_mem", bus.wb_data, 16'h1234);

        $display("[TB] random operations");
        for (int n = 0; n < 400; n++) begin
            r_valid = ($urandom_range(0, 9) != 0);
            r_alu   = 3'($urandom_range(0, 7));
            r_ra    = 4'($urandom_range(0, 15));
            r_rb    = 4'($urandom_range(0, 15));
            r_w     = 4'($urandom_range(0, 15));
            r_wen   = ($urandom_range(0, 3) != 0);
            r_da    = 8'(8'h40 + $urandom_range(0, 7));
            r_dwe   = ($urandom_range(0, 2) == 0);
            r_mux   = m_known[r_da] ? 1'($urandom_range(0, 1)) : 1'b0;
            apply_stimulus(r_valid, r_alu, r_ra, r_rb, r_w, r_wen, r_mux, r_da, r_dwe);
        end

        $display("[TB] reset mid-stream");
        bus.op_valid = 1'b1; bus.op_alu_s = 3'd7; bus.op_ra_addr = 4'd4;
        bus.op_w_addr = 4'd9; bus.op_w_en = 1'b1; bus.op_d_we = 1'b0; bus.op_mux_s = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_alu_out",  bus.alu_out,   16'h0);
        check("mid_rst_zero",     bus.alu_zero,  1'b1);
        check("mid_rst_carry",    bus.alu_carry, 1'b0);
        check("mid_rst_wb_valid", bus.wb_valid,  1'b0);
        check("mid_rst_wb_addr",  bus.wb_addr,   4'h0);
        check("mid_rst_wb_data",  bus.wb_data,   16'h0);
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1, 3'd3, 4'(i), 4'(i), 4'd0, 0, 0, 8'h00, 0);
            check("post_rst_reg", bus.alu_out, 16'h0);
        end
        idle_inputs();

        $display("[TB] DW=8 variant");
        v_op(3'd7, 3'd0, 3'd0, 3'd1, 1, 0, 4'h0, 0);
        check("v_inc", vbus.alu_out, 8'h01);
        v_op(3'd2, 3'd0, 3'd1, 3'd2, 1, 0, 4'h0, 0);
        check("v_sub", vbus.alu_out, 8'hFF);
        check("v_borrow", vbus.alu_carry, 1'b1);
        v_op(3'd1, 3'd2, 3'd1, 3'd0, 0, 0, 4'h0, 0);
        check("v_add", vbus.alu_out, 8'h00);
        check("v_add_carry", vbus.alu_carry, 1'b1);
        check("v_add_zero", vbus.alu_zero, 1'b1);
        v_op(3'd0, 3'd2, 3'd0, 3'd0, 0, 0, 4'hF, 1);
        v_op(3'd0, 3'd0, 3'd0, 3'd3, 1, 1, 4'hF, 0);
        check("v_mem_top", vbus.wb_data, 8'hFF);
        v_op(3'd3, 3'd3, 3'd0, 3'd0, 0, 0, 4'h0, 0);
        check("v_fwd", vbus.alu_a, 8'hFF);
        idle_inputs();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
